// File: rtl/mmio_map_pkg.sv
// Shared MMIO map for the frame master: select/register codes, step encoding
// and FSM states.
package mmio_map_pkg;

  localparam logic [4:0] SEL_PHY1 = 5'd0;
  localparam logic [4:0] SEL_PHY2 = 5'd1;
  localparam logic [4:0] SEL_GCM1 = 5'd4;
  localparam logic [4:0] SEL_GCM2 = 5'd5;
  localparam logic [4:0] SEL_VGA1 = 5'd8;
  localparam logic [4:0] SEL_VGA2 = 5'd9;
  localparam logic [4:0] SEL_COLL = 5'd12;

  localparam logic [4:0] REG_POS    = 5'd0;
  localparam logic [4:0] REG_CTRL   = 5'd4;
  localparam logic [4:0] REG_COLLIS = 5'd7;

  typedef enum logic {OP_RD = 1'b0, OP_WR = 1'b1} op_e;
  typedef enum logic {OPD_T = 1'b0, OPD_P = 1'b1} opd_e;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RUN, ST_DONE} state_e;

  typedef struct packed {
    logic        last;
    op_e         op;
    opd_e        opd;
    logic [12:0] addr;
  } step_t;

  function automatic logic [12:0] mmio_addr(input logic [4:0] sel, input logic [4:0] rg);
    return {1'b1, sel, rg, 2'b00};
  endfunction

endpackage

// File: rtl/mmio_frame_rom.sv
// Per-frame transfer table: step index to {last, op, operand, address}.
module mmio_frame_rom import mmio_map_pkg::*; #(
  parameter int NUM_PLAYERS = 2
) (
  input  logic [3:0] idx_i,
  output step_t      step_o
);

  always_comb begin
    step_o = '{1'b0, OP_RD, OPD_T, 13'h0};
    case (idx_i)
      4'd0:  step_o = '{1'b0, OP_RD, OPD_T, mmio_addr(SEL_GCM1, REG_POS)};
      4'd1:  step_o = '{1'b0, OP_WR, OPD_T, mmio_addr(SEL_PHY1, REG_CTRL)};
      4'd2:  step_o = '{1'b0, OP_RD, OPD_T, mmio_addr(SEL_GCM2, REG_POS)};
      4'd3:  step_o = '{1'b0, OP_WR, OPD_T, mmio_addr(SEL_PHY2, REG_CTRL)};
      4'd4:  step_o = '{1'b0, OP_RD, OPD_P, mmio_addr(SEL_PHY1, REG_POS)};
      4'd5:  step_o = '{1'b0, OP_WR, OPD_P, mmio_addr(SEL_VGA1, REG_POS)};
      4'd6:  step_o = '{1'b0, OP_WR, OPD_P, mmio_addr(SEL_COLL, REG_POS)};
      4'd7:  step_o = '{1'b0, OP_RD, OPD_T, mmio_addr(SEL_COLL, REG_POS)};
      4'd8:  step_o = '{1'b0, OP_WR, OPD_T, mmio_addr(SEL_PHY1, REG_COLLIS)};
      4'd9:  step_o = '{1'b0, OP_RD, OPD_P, mmio_addr(SEL_PHY2, REG_POS)};
      4'd10: step_o = '{1'b0, OP_WR, OPD_P, mmio_addr(SEL_VGA2, REG_POS)};
      4'd11: step_o = '{1'b0, OP_WR, OPD_P, mmio_addr(SEL_COLL, REG_POS)};
      4'd12: step_o = '{1'b0, OP_RD, OPD_T, mmio_addr(SEL_COLL, REG_POS)};
      4'd13: step_o = '{1'b0, OP_WR, OPD_T, mmio_addr(SEL_PHY2, REG_COLLIS)};
      default: step_o = '{1'b0, OP_RD, OPD_T, 13'h0};
    endcase
    // Single-player frames end after the player-1 collision write-back.
    step_o.last = (idx_i == 4'd13) || ((NUM_PLAYERS == 1) && (idx_i == 4'd8));
  end

endmodule

// File: rtl/mmio_frame_master.sv
// Frame-driven MMIO bus initiator: on each tick, shuffles controller, position
// and collision data between coprocessors while holding the bus grant.
module mmio_frame_master import mmio_map_pkg::*; #(
  parameter int NUM_PLAYERS = 2,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   frame_tick,
  output logic                   bus_req,
  input  logic                   bus_gnt,
  output logic [12:0]            address,
  output logic [31:0]            data_out,
  output logic                   wren,
  input  logic [31:0]            data_in,
  output logic                   busy,
  output logic                   done,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic [7:0]             overrun_count
);

  state_e                 state_q, state_d;
  logic [3:0]             step_q, step_d;
  logic [31:0]            t_q, t_d, p_q, p_d;
  logic [FRAME_CNT_W-1:0] frame_q, frame_d;
  logic [7:0]             ovr_q, ovr_d;
  step_t                  step;

  mmio_frame_rom #(.NUM_PLAYERS(NUM_PLAYERS)) u_rom (
    .idx_i  (step_q),
    .step_o (step)
  );

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    t_d      = t_q;
    p_d      = p_q;
    frame_d  = frame_q;
    ovr_d    = ovr_q;
    bus_req  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    address  = 13'h0;
    data_out = 32'h0;
    wren     = 1'b0;

    if (frame_tick && (state_q != ST_IDLE) && (ovr_q != 8'hFF))
      ovr_d = ovr_q + 8'd1;

    case (state_q)
      ST_IDLE: if (frame_tick) begin
        state_d = ST_REQ;
        step_d  = 4'd0;
      end
      ST_REQ: begin
        bus_req = 1'b1;
        busy    = 1'b1;
        if (bus_gnt) state_d = ST_RUN;
      end
      ST_RUN: begin
        bus_req = 1'b1;
        busy    = 1'b1;
        // Without a grant the bus is parked at zero and the step is held.
        if (bus_gnt) begin
          address = step.addr;
          if (step.op == OP_WR) begin
            wren     = 1'b1;
            data_out = (step.opd == OPD_P) ? p_q : t_q;
          end else if (step.opd == OPD_P) begin
            p_d = data_in;
          end else begin
            t_d = data_in;
          end
          if (step.last)
            state_d = ST_DONE;
          else if ((NUM_PLAYERS == 1) && (step_q == 4'd1))
            step_d = 4'd4;
          else
            step_d = step_q + 4'd1;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        frame_d = frame_q + FRAME_CNT_W'(1);
        state_d = ST_IDLE;
        step_d  = 4'd0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      step_q  <= 4'd0;
      t_q     <= 32'h0;
      p_q     <= 32'h0;
      frame_q <= '0;
      ovr_q   <= 8'h0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      t_q     <= t_d;
      p_q     <= p_d;
      frame_q <= frame_d;
      ovr_q   <= ovr_d;
    end
  end

  assign frame_count   = frame_q;
  assign overrun_count = ovr_q;

endmodule

// File: tb/tb_mmio_frame_master.sv
// Scoreboard bench for mmio_frame_master: two-player and single-player instances
// against a constant-valued MMIO slave model.
module tb_mmio_frame_master;

  typedef struct {
    logic        wr;
    logic [12:0] addr;
    logic [31:0] data;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset = 1'b1;
  logic        tick1 = 1'b0, gnt1 = 1'b1;
  logic        req1, wren1, busy1, done1;
  logic [12:0] addr1;
  logic [31:0] dout1, din1;
  logic [15:0] fc1;
  logic [7:0]  ovr1;

  logic        tick2 = 1'b0, gnt2 = 1'b1;
  logic        req2, wren2, busy2, done2;
  logic [12:0] addr2;
  logic [31:0] dout2, din2;
  logic [15:0] fc2;
  logic [7:0]  ovr2;

  logic [31:0] salt = 32'h0;
  int total = 0, passed = 0;
  int bus2 = 0, forbid2 = 0;
  bit mon_en = 1'b0;
  exp_t q1[$], q2[$];

  logic [12:0] TA [14] = '{13'h1200, 13'h1010, 13'h1280, 13'h1090, 13'h1000, 13'h1400, 13'h1600,
                           13'h1600, 13'h101C, 13'h1080, 13'h1480, 13'h1600, 13'h1600, 13'h109C};
  bit TW [14] = '{0, 1, 0, 1, 0, 1, 1, 0, 1, 0, 1, 1, 0, 1};
  bit TP [14] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 1, 1, 0, 0};

  function automatic logic [31:0] slave_rd(input logic [12:0] a, input logic [31:0] s);
    case (a)
      13'h1200: return 32'h0000_0005 ^ s;
      13'h1280: return 32'h0000_0006 ^ s;
      13'h1000: return 32'h0160_00FA ^ s;
      13'h1080: return 32'h0200_0100 ^ s;
      13'h1600: return 32'h0000_0003 ^ s;
      default:  return 32'h0;
    endcase
  endfunction

  assign din1 = slave_rd(addr1, salt);
  assign din2 = slave_rd(addr2, salt);

  mmio_frame_master #(.NUM_PLAYERS(2), .FRAME_CNT_W(16)) dut (
    .clock(clock), .reset(reset), .frame_tick(tick1), .bus_req(req1), .bus_gnt(gnt1),
    .address(addr1), .data_out(dout1), .wren(wren1), .data_in(din1), .busy(busy1),
    .done(done1), .frame_count(fc1), .overrun_count(ovr1)
  );

  mmio_frame_master #(.NUM_PLAYERS(1), .FRAME_CNT_W(16)) dut1p (
    .clock(clock), .reset(reset), .frame_tick(tick2), .bus_req(req2), .bus_gnt(gnt2),
    .address(addr2), .data_out(dout2), .wren(wren2), .data_in(din2), .busy(busy2),
    .done(done2), .frame_count(fc2), .overrun_count(ovr2)
  );

  // Bus monitors: every granted bus cycle must match the next expected step.
  always @(negedge clock) if (mon_en && addr1 !== 13'h0) begin
    exp_t e;
    total++;
    if (q1.size() == 0)
      $display("FAIL dut_unexpected_bus got addr=%h wren=%b required no bus cycle", addr1, wren1);
    else begin
      e = q1.pop_front();
      if (wren1 !== e.wr || addr1 !== e.addr || (e.wr && dout1 !== e.data))
        $display("FAIL dut_bus got addr=%h wren=%b data=%h required addr=%h wren=%b data=%h",
                 addr1, wren1, dout1, e.addr, e.wr, e.data);
      else passed++;
    end
  end

  always @(negedge clock) if (mon_en && addr2 !== 13'h0) begin
    exp_t e;
    bus2++;
    if (addr2 == 13'h1090 || addr2 == 13'h1480 || addr2 == 13'h109C) forbid2++;
    total++;
    if (q2.size() == 0)
      $display("FAIL dut1p_unexpected_bus got addr=%h wren=%b required no bus cycle", addr2, wren2);
    else begin
      e = q2.pop_front();
      if (wren2 !== e.wr || addr2 !== e.addr || (e.wr && dout2 !== e.data))
        $display("FAIL dut1p_bus got addr=%h wren=%b data=%h required addr=%h wren=%b data=%h",
                 addr2, wren2, dout2, e.addr, e.wr, e.data);
      else passed++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Expected bus cycles for steps 0..upto, modelling the T/P registers.
  task automatic push_frame(input int which, input int np, input int upto);
    logic [31:0] t, p;
    exp_t e;
    t = 32'h0;
    p = 32'h0;
    for (int i = 0; i <= upto; i++) begin
      if (np == 1 && (i == 2 || i == 3 || i >= 9)) continue;
      e.wr = TW[i];
      e.addr = TA[i];
      e.data = 32'h0;
      if (!TW[i]) begin
        if (TP[i]) p = slave_rd(TA[i], salt);
        else t = slave_rd(TA[i], salt);
      end else e.data = TP[i] ? p : t;
      if (which == 1) q1.push_back(e);
      else q2.push_back(e);
    end
  endtask

  // Ticks dut, optionally drops grant, pulses extra ticks per tick_mask bit n.
  // Returns n = cycle index of done (tick cycle is 0); ends one cycle after done.
  task automatic drive_frame(input int stall_at, input int stall_len, input logic [31:0] tick_mask,
                             output int n, output int gap_bad);
    n = 0;
    gap_bad = 0;
    tick1 = 1'b1;
    cyc();
    n = 1;
    while (n < 200) begin
      gnt1 = !(stall_len > 0 && n >= stall_at && n < stall_at + stall_len);
      tick1 = (n < 32) ? tick_mask[n] : 1'b0;
      #1;
      if (!gnt1 && (wren1 !== 1'b0 || addr1 !== 13'h0 || dout1 !== 32'h0 || req1 !== 1'b1))
        gap_bad++;
      if (done1 === 1'b1) break;
      cyc();
      n++;
    end
    cyc();
    tick1 = 1'b0;
    gnt1 = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) cyc();
    total++;
    if ({req1, wren1, busy1, done1} !== 4'b0000)
      $display("FAIL reset_ctrl got req/wren/busy/done=%b required 0000", {req1, wren1, busy1, done1});
    else passed++;
    total++;
    if (addr1 !== 13'h0 || dout1 !== 32'h0)
      $display("FAIL reset_bus got addr=%h data=%h required 0/0", addr1, dout1);
    else passed++;
    total++;
    if (fc1 !== 16'h0 || ovr1 !== 8'h0 || fc2 !== 16'h0 || ovr2 !== 8'h0)
      $display("FAIL reset_counters got fc=%0d ovr=%0d fc1p=%0d ovr1p=%0d required 0", fc1, ovr1, fc2, ovr2);
    else passed++;
    reset = 1'b0;
    mon_en = 1'b1;
    cyc();
  endtask

  task automatic test_frame();
    int n, gb;
    salt = 32'h0;
    push_frame(1, 2, 13);
    drive_frame(0, 0, 32'h0, n, gb);
    total++;
    if (n !== 16) $display("FAIL frame_done_latency got %0d required 16", n);
    else passed++;
    total++;
    if (fc1 !== 16'd1) $display("FAIL frame_count got %0d required 1", fc1);
    else passed++;
    total++;
    if (q1.size() != 0) $display("FAIL frame_missing_steps got %0d left required 0", q1.size());
    else passed++;
    total++;
    if (busy1 !== 1'b0 || req1 !== 1'b0) $display("FAIL frame_idle got busy=%b req=%b required 0/0", busy1, req1);
    else passed++;
  endtask

  task automatic test_stall();
    int n, gb;
    salt = 32'hA5A5_0000;
    push_frame(1, 2, 13);
    drive_frame(8, 3, 32'h0, n, gb);
    total++;
    if (n !== 19) $display("FAIL stall_done_latency got %0d required 19", n);
    else passed++;
    total++;
    if (gb !== 0) $display("FAIL stall_bus_parked got %0d bad cycles required 0", gb);
    else passed++;
    total++;
    if (fc1 !== 16'd2) $display("FAIL stall_frame_count got %0d required 2", fc1);
    else passed++;
  endtask

  task automatic test_overrun();
    int n, gb;
    salt = 32'h0000_1230;
    push_frame(1, 2, 13);
    drive_frame(0, 0, 32'h0000_0224, n, gb);
    total++;
    if (n !== 16) $display("FAIL overrun_done_latency got %0d required 16", n);
    else passed++;
    total++;
    if (ovr1 !== 8'd3) $display("FAIL overrun_count got %0d required 3", ovr1);
    else passed++;
    repeat (3) cyc();
    total++;
    if (busy1 !== 1'b0 || fc1 !== 16'd3) $display("FAIL overrun_no_restart got busy=%b fc=%0d required 0/3", busy1, fc1);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int n, gb;
    salt = 32'h00FF_0000;
    push_frame(1, 2, 13);
    drive_frame(0, 0, 32'h0001_0000, n, gb);
    total++;
    if (ovr1 !== 8'd4 || busy1 !== 1'b0)
      $display("FAIL b2b_tick_in_done got ovr=%0d busy=%b required 4/0", ovr1, busy1);
    else passed++;
    salt = 32'h0F0F_0F0F;
    push_frame(1, 2, 13);
    drive_frame(0, 0, 32'h0, n, gb);
    total++;
    if (n !== 16 || fc1 !== 16'd5) $display("FAIL b2b_second_frame got n=%0d fc=%0d required 16/5", n, fc1);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int n, gb;
    salt = 32'h7700_0000;
    push_frame(1, 2, 8);
    tick1 = 1'b1;
    cyc();
    tick1 = 1'b0;
    n = 1;
    while (n < 10) begin
      cyc();
      n++;
    end
    reset = 1'b1;
    cyc();
    total++;
    if (wren1 !== 1'b0 || busy1 !== 1'b0 || req1 !== 1'b0 || addr1 !== 13'h0)
      $display("FAIL reset_mid_outputs got wren=%b busy=%b req=%b addr=%h required 0", wren1, busy1, req1, addr1);
    else passed++;
    total++;
    if (fc1 !== 16'h0 || ovr1 !== 8'h0) $display("FAIL reset_mid_counters got fc=%0d ovr=%0d required 0/0", fc1, ovr1);
    else passed++;
    reset = 1'b0;
    cyc();
    total++;
    if (q1.size() != 0) $display("FAIL reset_mid_steps got %0d left required 0", q1.size());
    else passed++;
    salt = 32'h0000_00C0;
    push_frame(1, 2, 13);
    drive_frame(0, 0, 32'h0, n, gb);
    total++;
    if (n !== 16 || fc1 !== 16'd1) $display("FAIL reset_mid_restart got n=%0d fc=%0d required 16/1", n, fc1);
    else passed++;
  endtask

  task automatic test_saturate();
    int n;
    gnt1 = 1'b0;
    tick1 = 1'b1;
    cyc();
    repeat (100) cyc();
    total++;
    if (ovr1 !== 8'd100 || req1 !== 1'b1 || addr1 !== 13'h0)
      $display("FAIL sat_partial got ovr=%0d req=%b addr=%h required 100/1/0", ovr1, req1, addr1);
    else passed++;
    repeat (200) cyc();
    tick1 = 1'b0;
    #1;
    total++;
    if (ovr1 !== 8'd255) $display("FAIL sat_overrun got %0d required 255", ovr1);
    else passed++;
    salt = 32'h3C00_0000;
    push_frame(1, 2, 13);
    gnt1 = 1'b1;
    n = 0;
    while (done1 !== 1'b1 && n < 100) begin
      cyc();
      n++;
    end
    total++;
    if (n !== 15) $display("FAIL sat_done_after_grant got %0d required 15", n);
    else passed++;
    cyc();
    total++;
    if (ovr1 !== 8'd255 || fc1 !== 16'd2) $display("FAIL sat_final got ovr=%0d fc=%0d required 255/2", ovr1, fc1);
    else passed++;
  endtask

  task automatic test_one_player();
    int n;
    salt = 32'h0000_9000;
    push_frame(2, 1, 13);
    tick2 = 1'b1;
    cyc();
    tick2 = 1'b0;
    n = 1;
    while (done2 !== 1'b1 && n < 100) begin
      cyc();
      n++;
    end
    total++;
    if (n !== 9) $display("FAIL np1_done_latency got %0d required 9", n);
    else passed++;
    cyc();
    total++;
    if (bus2 !== 7 || forbid2 !== 0)
      $display("FAIL np1_bus_cycles got %0d cycles %0d forbidden required 7/0", bus2, forbid2);
    else passed++;
    total++;
    if (fc2 !== 16'd1 || q2.size() != 0) $display("FAIL np1_final got fc=%0d left=%0d required 1/0", fc2, q2.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_stall();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    test_one_player();
    repeat (2) cyc();
    total++;
    if (q1.size() != 0) $display("FAIL end_queue got %0d left required 0", q1.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
